// File: rtl/fu_logic_pipe.sv
// Pipelined bitwise-logic functional unit: one issue per cycle, LATENCY-deep
// result pipeline whose head is held until the broadcast queue accepts it.
module fu_logic_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1,
  parameter int TAG_WIDTH  = 7,
  parameter int OCC_WIDTH  = $clog2(LATENCY + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  output logic                  idle,
  input  logic [2:0]            op,
  input  logic [TAG_WIDTH-1:0]  executionTag_in,
  input  logic [DATA_WIDTH-1:0] data_0,
  input  logic [DATA_WIDTH-1:0] data_1,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  done,
  output logic [TAG_WIDTH-1:0]  executionTag_out,
  input  logic                  queued,
  output logic [OCC_WIDTH-1:0]  occupancy
);

  // Handshake: the head entry (done=1) retires on an edge where queued=1;
  // while done=1 and queued=0 the whole pipeline holds and issues are dropped.
  logic [LATENCY-1:0]    vld_q, vld_d;
  logic [DATA_WIDTH-1:0] res_q [LATENCY];
  logic [DATA_WIDTH-1:0] res_d [LATENCY];
  logic [TAG_WIDTH-1:0]  tag_q [LATENCY];
  logic [TAG_WIDTH-1:0]  tag_d [LATENCY];
  logic [OCC_WIDTH-1:0]  occ_q, occ_d;

  logic                  stall;
  logic                  issue;
  logic                  retire;
  logic [DATA_WIDTH-1:0] func;

  always_comb begin
    func = '0;
    case (op)
      3'd0: func = data_0 & data_1;
      3'd1: func = data_0 | data_1;
      3'd2: func = data_0 ^ data_1;
      3'd3: func = ~(data_0 ^ data_1);
      3'd4: func = data_0 & ~data_1;
      3'd5: func = data_0 | ~data_1;
      3'd6: func = ~(data_0 | data_1);
      3'd7: func = ~(data_0 & data_1);
      default: func = '0;
    endcase
  end

  always_comb begin
    stall  = vld_q[LATENCY-1] & ~queued;
    issue  = ce & ~stall;
    retire = vld_q[LATENCY-1] & queued;

    vld_d = vld_q;
    res_d = res_q;
    tag_d = tag_q;
    occ_d = occ_q;

    if (!stall) begin
      vld_d[0] = issue;
      if (issue) begin
        res_d[0] = func;
        tag_d[0] = executionTag_in;
      end
      // Bubbles move through freely; payload only moves with a valid entry.
      for (int k = 1; k < LATENCY; k++) begin
        vld_d[k] = vld_q[k-1];
        if (vld_q[k-1]) begin
          res_d[k] = res_q[k-1];
          tag_d[k] = tag_q[k-1];
        end
      end
    end

    case ({issue, retire})
      2'b10:   occ_d = occ_q + OCC_WIDTH'(1);
      2'b01:   occ_d = occ_q - OCC_WIDTH'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      occ_q <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        res_q[k] <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      occ_q <= occ_d;
      res_q <= res_d;
      tag_q <= tag_d;
    end
  end

  assign idle             = ~stall;
  assign done             = vld_q[LATENCY-1];
  assign result           = res_q[LATENCY-1];
  assign executionTag_out = tag_q[LATENCY-1];
  assign occupancy        = occ_q;

endmodule

// File: tb/tb_fu_logic_pipe.sv
// Bench for fu_logic_pipe: four instances (LATENCY 1..4) share one stimulus
// stream and are checked against a position-tracking queue model.
module tb_fu_logic_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [2:0]  op;
  logic [6:0]  tag_in;
  logic [31:0] d0, d1;
  logic        queued;

  logic        o_idle [4];
  logic        o_done [4];
  logic [31:0] o_res  [4];
  logic [6:0]  o_tag  [4];
  logic [3:0]  o_occ  [4];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic [$clog2(g+2)-1:0] occ_w;
    fu_logic_pipe #(.DATA_WIDTH(32), .LATENCY(g+1), .TAG_WIDTH(7)) u_dut (
      .clk              (clk),
      .rst              (rst),
      .ce               (ce),
      .idle             (o_idle[g]),
      .op               (op),
      .executionTag_in  (tag_in),
      .data_0           (d0),
      .data_1           (d1),
      .result           (o_res[g]),
      .done             (o_done[g]),
      .executionTag_out (o_tag[g]),
      .queued           (queued),
      .occupancy        (occ_w)
    );
    assign o_occ[g] = 4'(occ_w);
  end

  // Model: per instance, in-flight entries oldest first with their stage number.
  int          m_cnt [4];
  int          m_pos [4][8];
  logic [6:0]  m_tag [4][8];
  logic [31:0] m_res [4][8];

  function automatic logic [31:0] logic_f(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a ^ b);
      3'd4: return a & ~b;
      3'd5: return a | ~b;
      3'd6: return ~(a | b);
      default: return ~(a & b);
    endcase
  endfunction

  function automatic logic m_done(input int i);
    return (m_cnt[i] > 0) && (m_pos[i][0] == i + 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  task automatic model_edge(input int i, input logic c, input logic [6:0] t,
                            input logic [31:0] r, input logic q);
    if (m_done(i) && !q) return;
    if (m_done(i)) begin
      for (int k = 0; k < m_cnt[i] - 1; k++) begin
        m_pos[i][k] = m_pos[i][k+1];
        m_tag[i][k] = m_tag[i][k+1];
        m_res[i][k] = m_res[i][k+1];
      end
      m_cnt[i]--;
    end
    for (int k = 0; k < m_cnt[i]; k++) m_pos[i][k]++;
    if (c) begin
      m_pos[i][m_cnt[i]] = 1;
      m_tag[i][m_cnt[i]] = t;
      m_res[i][m_cnt[i]] = r;
      m_cnt[i]++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("done_L%0d", i+1), 32'(o_done[i]), 32'(m_done(i)));
      chk($sformatf("occ_L%0d", i+1), 32'(o_occ[i]), 32'(m_cnt[i]));
      if (m_done(i)) begin
        chk($sformatf("tag_L%0d", i+1), 32'(o_tag[i]), 32'(m_tag[i][0]));
        chk($sformatf("res_L%0d", i+1), o_res[i], m_res[i][0]);
      end
    end
  endtask

  task automatic tick(input logic c, input logic [2:0] o, input logic [6:0] t,
                      input logic [31:0] a, input logic [31:0] b, input logic q);
    logic [31:0] f;
    ce = c; op = o; tag_in = t; d0 = a; d1 = b; queued = q;
    #1;
    for (int i = 0; i < 4; i++)
      chk($sformatf("idle_L%0d", i+1), 32'(o_idle[i]), 32'(!(m_done(i) && !q)));
    f = logic_f(o, a, b);
    for (int i = 0; i < 4; i++) model_edge(i, c, t, f, q);
    @(posedge clk);
    #2;
    check_outputs();
  endtask

  task automatic idle_ticks(input int n);
    for (int j = 0; j < n; j++) tick(1'b0, 3'd0, 7'd0, 32'd0, 32'd0, 1'b1);
  endtask

  initial begin
    logic [31:0] ops_exp [8];
    int peak;
    ops_exp[0] = 32'h00F0_000F; ops_exp[1] = 32'hFFF0_0FFF;
    ops_exp[2] = 32'hFF00_0FF0; ops_exp[3] = 32'h00FF_F00F;
    ops_exp[4] = 32'hF000_00F0; ops_exp[5] = 32'hF0FF_F0FF;
    ops_exp[6] = 32'h000F_F000; ops_exp[7] = 32'hFF0F_FFF0;

    // Reset state
    rst = 1'b0; ce = 1'b0; op = 3'd0; tag_in = 7'd0; d0 = '0; d1 = '0; queued = 1'b0;
    model_reset();
    #12;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_idle_L%0d", i+1), 32'(o_idle[i]), 32'd1);
      chk($sformatf("rst_done_L%0d", i+1), 32'(o_done[i]), 32'd0);
      chk($sformatf("rst_occ_L%0d", i+1), 32'(o_occ[i]), 32'd0);
      chk($sformatf("rst_res_L%0d", i+1), o_res[i], 32'd0);
      chk($sformatf("rst_tag_L%0d", i+1), 32'(o_tag[i]), 32'd0);
    end
    rst = 1'b1;

    // All eight ops back-to-back, fixed results on the LATENCY=1 unit
    for (int k = 0; k < 8; k++) begin
      tick(1'b1, 3'(k), 7'd5, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b1);
      chk($sformatf("ops_done_op%0d", k), 32'(o_done[0]), 32'd1);
      chk($sformatf("ops_res_op%0d", k), o_res[0], ops_exp[k]);
      chk($sformatf("ops_tag_op%0d", k), 32'(o_tag[0]), 32'd5);
    end
    idle_ticks(4);

    // LATENCY=4 back-to-back stream of tags 1..5
    peak = 0;
    for (int j = 0; j < 10; j++) begin
      if (j < 5) tick(1'b1, 3'd2, 7'(j + 1), $urandom, $urandom, 1'b1);
      else       tick(1'b0, 3'd0, 7'd0, 32'd0, 32'd0, 1'b1);
      if (int'(o_occ[3]) > peak) peak = int'(o_occ[3]);
      chk($sformatf("pipe_done_j%0d", j), 32'(o_done[3]), 32'(j >= 3 && j <= 7));
      if (j >= 3 && j <= 7) chk($sformatf("pipe_tag_j%0d", j), 32'(o_tag[3]), 32'(j - 2));
    end
    chk("pipe_peak_occ", 32'(peak), 32'd4);

    // LATENCY=3 backpressure: fill, drop tag 13, then drain in order
    for (int j = 0; j < 3; j++) tick(1'b1, 3'd1, 7'(10 + j), $urandom, $urandom, 1'b0);
    chk("bp_idle_full", 32'(o_idle[2]), 32'd0);
    chk("bp_occ_full", 32'(o_occ[2]), 32'd3);
    tick(1'b1, 3'd1, 7'd13, $urandom, $urandom, 1'b0);
    chk("bp_occ_after_drop", 32'(o_occ[2]), 32'd3);
    chk("bp_head_after_drop", 32'(o_tag[2]), 32'd10);
    tick(1'b0, 3'd0, 7'd0, 32'd0, 32'd0, 1'b1);
    chk("bp_head_11", 32'(o_tag[2]), 32'd11);
    tick(1'b0, 3'd0, 7'd0, 32'd0, 32'd0, 1'b1);
    chk("bp_head_12", 32'(o_tag[2]), 32'd12);
    tick(1'b0, 3'd0, 7'd0, 32'd0, 32'd0, 1'b1);
    chk("bp_drained_done", 32'(o_done[2]), 32'd0);
    chk("bp_drained_occ", 32'(o_occ[2]), 32'd0);
    idle_ticks(6);

    // LATENCY=2 simultaneous issue and retire
    tick(1'b1, 3'd3, 7'd20, $urandom, $urandom, 1'b0);
    tick(1'b1, 3'd3, 7'd21, $urandom, $urandom, 1'b0);
    chk("sim_occ_before", 32'(o_occ[1]), 32'd2);
    chk("sim_head_before", 32'(o_tag[1]), 32'd20);
    tick(1'b1, 3'd3, 7'd22, $urandom, $urandom, 1'b1);
    chk("sim_occ_after", 32'(o_occ[1]), 32'd2);
    chk("sim_done_after", 32'(o_done[1]), 32'd1);
    chk("sim_head_after", 32'(o_tag[1]), 32'd21);
    idle_ticks(6);

    // Asynchronous reset with entries in flight
    for (int j = 0; j < 3; j++) tick(1'b1, 3'd0, 7'(30 + j), $urandom, $urandom, 1'b1);
    chk("ar_occ_before", 32'(o_occ[3]), 32'd3);
    #1 rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ar_done_L%0d", i+1), 32'(o_done[i]), 32'd0);
      chk($sformatf("ar_occ_L%0d", i+1), 32'(o_occ[i]), 32'd0);
      chk($sformatf("ar_idle_L%0d", i+1), 32'(o_idle[i]), 32'd1);
    end
    #1 rst = 1'b1;
    model_reset();
    for (int j = 0; j < 6; j++) begin
      if (j == 0) tick(1'b1, 3'd4, 7'd7, $urandom, $urandom, 1'b1);
      else        tick(1'b0, 3'd0, 7'd0, 32'd0, 32'd0, 1'b1);
      chk($sformatf("ar_new_done_j%0d", j), 32'(o_done[3]), 32'(j == 3));
      if (j == 3) chk("ar_new_tag", 32'(o_tag[3]), 32'd7);
    end

    // LATENCY=3 bubble between two issues
    for (int j = 0; j < 7; j++) begin
      if (j == 0)      tick(1'b1, 3'd5, 7'd40, $urandom, $urandom, 1'b1);
      else if (j == 2) tick(1'b1, 3'd6, 7'd41, $urandom, $urandom, 1'b1);
      else             tick(1'b0, 3'd0, 7'd0, 32'd0, 32'd0, 1'b1);
      chk($sformatf("bub_done_j%0d", j), 32'(o_done[2]), 32'(j == 2 || j == 4));
      if (j == 2) chk("bub_tag_40", 32'(o_tag[2]), 32'd40);
      if (j == 4) chk("bub_tag_41", 32'(o_tag[2]), 32'd41);
    end

    // Random traffic against the model
    for (int j = 0; j < 400; j++) begin
      tick(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)),
           $urandom, $urandom, 1'($urandom_range(0, 3) != 0));
    end
    idle_ticks(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
